// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//   Registered program counter. Each cycle it selects the next PC from
//   {0, jump target, PC+1, hold, return address}. The output drives the
//   instruction ROM address.
//
//   Optional feature macro: PC_CALL_STACK_EN
//     defined   : return-address stack of DEPTH entries, call/ret handling and
//                 sticky overflow/underflow flags are built.
//     undefined : no stack storage; call/ret are ignored and overflow/underflow
//                 are tied to 0. The port list is the same in both builds.
//
// Parameters
//   WIDTH  PC / address width in bits
//   DEPTH  return-address stack entries (power of 2, >= 2)
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   in         in   WIDTH  jump / call target
//   load       in   1      jump: out <= in
//   inc        in   1      advance: out <= out + 1
//   call       in   1      push out+1, out <= in (stack build only)
//   ret        in   1      out <= popped address (stack build only)
//   out        out  WIDTH  current PC (registered)
//   wrap       out  1      one-cycle pulse when inc wrapped all-ones to 0
//   overflow   out  1      sticky: call issued with stack full
//   underflow  out  1      sticky: ret issued with stack empty
// -----------------------------------------------------------------------------
module program_counter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] out_d, out_q;
  logic             wrap_d, wrap_q;
  logic [WIDTH-1:0] pc_plus1;

  assign pc_plus1 = out_q + WIDTH'(1);

`ifdef PC_CALL_STACK_EN

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;  // must represent 0..DEPTH inclusive

  logic [SP_W-1:0]  sp_d, sp_q;
  logic             overflow_d, overflow_q;
  logic             underflow_d, underflow_q;
  logic             push_en;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;
  logic [WIDTH-1:0] mem [DEPTH];

  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    out_d       = out_q;
    wrap_d      = 1'b0;
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_en     = 1'b0;

    if (ret) begin
      // ret outranks call, so a simultaneous call is dropped entirely.
      if (sp_q != '0) begin
        out_d = mem[pop_idx];
        sp_d  = sp_q - SP_W'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end else if (call) begin
      // The jump happens even when the push has to be dropped.
      out_d = in;
      if (sp_q != SP_W'(DEPTH)) begin
        push_en = 1'b1;
        sp_d    = sp_q + SP_W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end else if (load) begin
      out_d = in;
    end else if (inc) begin
      out_d  = pc_plus1;
      wrap_d = &out_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      wrap_q      <= 1'b0;
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      wrap_q      <= wrap_d;
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: stack storage is deliberately not reset; clearing sp makes every
  // entry unreachable, which is all a reset needs to guarantee.
  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      mem[push_idx] <= pc_plus1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`else

  // call/ret exist on the port list but have no function in this build.
  logic unused_stack_ports;
  assign unused_stack_ports = call ^ ret;

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (load) begin
      out_d = in;
    end else if (inc) begin
      out_d  = pc_plus1;
      wrap_d = &out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign overflow  = 1'b0;
  assign underflow = 1'b0;

`endif

  assign out  = out_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_program_counter.sv
// -----------------------------------------------------------------------------
// tb_program_counter
//   Self-checking bench for program_counter (WIDTH=16, DEPTH=4). The stimulus
//   process applies one control vector per cycle and queues the hand-computed
//   expected outputs; an independent monitor pops one entry after each rising
//   edge and compares it with what the DUT presents. Stack scenarios are built
//   when PC_CALL_STACK_EN is defined; otherwise the bench checks that call/ret
//   are ignored.
// -----------------------------------------------------------------------------
module tb_program_counter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  typedef struct {
    string       name;
    logic [15:0] out;
    logic        wrap;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] in = '0;
  logic             load = 1'b0;
  logic             inc = 1'b0;
  logic             call = 1'b0;
  logic             ret = 1'b0;
  logic [WIDTH-1:0] out;
  logic             wrap;
  logic             overflow;
  logic             underflow;

  exp_t sb_q[$];
  int   num_checks = 0;
  int   num_errors = 0;

  program_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .load      (load),
    .inc       (inc),
    .call      (call),
    .ret       (ret),
    .out       (out),
    .wrap      (wrap),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [18:0] act,
                       input logic [18:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got out=%h wrap=%b ovf=%b unf=%b, expected out=%h wrap=%b ovf=%b unf=%b",
               name, act[18:3], act[2], act[1], act[0],
               exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, queue what the DUT must
  // show after the next rising edge.
  task automatic step(input string name, input logic r, input logic l,
                      input logic i, input logic c, input logic rt,
                      input logic [15:0] din, input logic [15:0] e_out,
                      input logic e_wrap, input logic e_ovf, input logic e_unf);
    exp_t e;
    @(negedge clk);
    reset = r; load = l; inc = i; call = c; ret = rt; in = din;
    e.name = name; e.out = e_out; e.wrap = e_wrap; e.ovf = e_ovf; e.unf = e_unf;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: the DUT presents a new registered output every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, {out, wrap, overflow, underflow},
              {e.out, e.wrap, e.ovf, e.unf});
      end
    end
  end

  initial begin
    int budget;

    //   name          rst ld inc cl rt  in        out      w  ov un
    step("reset",      1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step("inc1",       0, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 0, 0);
    step("inc2",       0, 0, 1, 0, 0, 16'h0000, 16'h0002, 0, 0, 0);
    step("inc3",       0, 0, 1, 0, 0, 16'h0000, 16'h0003, 0, 0, 0);

    step("load_ffff",  0, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    step("inc_wrap",   0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    step("inc_after",  0, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 0, 0);

    step("load_beats", 0, 1, 1, 0, 0, 16'h0100, 16'h0100, 0, 0, 0);
    step("hold",       0, 0, 0, 0, 0, 16'h0000, 16'h0100, 0, 0, 0);

    step("load_10",    0, 1, 0, 0, 0, 16'd10,   16'd10,   0, 0, 0);
`ifdef PC_CALL_STACK_EN
    step("call_100",   0, 0, 0, 1, 0, 16'd100,  16'd100,  0, 0, 0);
    step("call_200",   0, 0, 0, 1, 0, 16'd200,  16'd200,  0, 0, 0);
    step("ret_101",    0, 0, 0, 0, 1, 16'd0,    16'd101,  0, 0, 0);
    step("ret_11",     0, 0, 0, 0, 1, 16'd0,    16'd11,   0, 0, 0);
    step("ret_empty",  0, 0, 0, 0, 1, 16'd0,    16'd11,   0, 0, 1);

    // Fill the stack (pushes 1,2,3,4), fifth push dropped.
    step("rst_fill",   1, 0, 0, 0, 0, 16'd0,    16'd0,    0, 0, 0);
    step("fill_c1",    0, 0, 0, 1, 0, 16'd1,    16'd1,    0, 0, 0);
    step("fill_c2",    0, 0, 0, 1, 0, 16'd2,    16'd2,    0, 0, 0);
    step("fill_c3",    0, 0, 0, 1, 0, 16'd3,    16'd3,    0, 0, 0);
    step("fill_c4",    0, 0, 0, 1, 0, 16'd4,    16'd4,    0, 0, 0);
    step("fill_c5_ov", 0, 0, 0, 1, 0, 16'd5,    16'd5,    0, 1, 0);
    step("drain_r1",   0, 0, 0, 0, 1, 16'd0,    16'd4,    0, 1, 0);
    step("drain_r2",   0, 0, 0, 0, 1, 16'd0,    16'd3,    0, 1, 0);
    step("drain_r3",   0, 0, 0, 0, 1, 16'd0,    16'd2,    0, 1, 0);
    step("drain_r4",   0, 0, 0, 0, 1, 16'd0,    16'd1,    0, 1, 0);
    step("drain_r5_un",0, 0, 0, 0, 1, 16'd0,    16'd1,    0, 1, 1);

    step("rst_cr",     1, 0, 0, 0, 0, 16'd0,    16'd0,    0, 0, 0);
    step("call_ret",   0, 0, 0, 1, 1, 16'd7,    16'd0,    0, 0, 1);
    step("rst_all",    1, 1, 1, 1, 1, 16'd55,   16'd0,    0, 0, 0);

    // Reset in the middle of a call sequence discards the pushed entry.
    step("mid_call",   0, 0, 0, 1, 0, 16'd20,   16'd20,   0, 0, 0);
    step("mid_reset",  1, 0, 0, 0, 0, 16'd0,    16'd0,    0, 0, 0);
    step("ret_gone",   0, 0, 0, 0, 1, 16'd0,    16'd0,    0, 0, 1);
`else
    step("call_ign",   0, 0, 0, 1, 0, 16'd100,  16'd10,   0, 0, 0);
    step("ret_ign",    0, 0, 0, 0, 1, 16'd0,    16'd10,   0, 0, 0);
    step("call_load",  0, 1, 0, 1, 1, 16'd100,  16'd100,  0, 0, 0);
    step("call_inc",   0, 0, 1, 1, 0, 16'd300,  16'd101,  0, 0, 0);
    step("rst_all",    1, 1, 1, 1, 1, 16'd55,   16'd0,    0, 0, 0);
`endif

    @(negedge clk);
    reset = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0; in = '0;

    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb_q.size() > 0) begin
      num_checks++;
      num_errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0",
               sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
